// File: rtl/spi_block_sequencer_pkg.sv
// rtl/spi_block_sequencer_pkg.sv - shared state encoding and constants for the SPI block sequencer
package spi_block_sequencer_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEFAULT_NUM_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_block_sequencer_cycle_timer.sv
// rtl/spi_block_sequencer_cycle_timer.sv - loadable down-counter shared by the gap and timeout counts
module spi_block_sequencer_cycle_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] remaining;

    // Reload on demand, otherwise count down toward zero while enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_value;
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - WIDTH'(1);
        end
    end

    // The loaded count is spent during the cycle in which one unit remains
    assign expired = (remaining <= WIDTH'(1));

endmodule

// File: rtl/spi_block_sequencer.sv
// rtl/spi_block_sequencer.sv - feeds a 128-bit block bytewise to the SPI master and gathers the replies
module spi_block_sequencer
    import spi_block_sequencer_pkg::*;
#(
    parameter int NUM_BYTES      = DEFAULT_NUM_BYTES,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          blk_valid,
    output logic                          blk_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0]   blk_in,
    output logic [BYTE_W*NUM_BYTES-1:0]   blk_out,
    output logic                          out_valid,
    output logic                          error,
    output logic                          busy,
    output logic                          m_start,
    output logic [BYTE_W-1:0]             m_data,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic [BYTE_W-1:0]             m_rdata
);

    localparam int TIMER_MAX = max_int(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    // Byte i of the block lives at packed index NUM_BYTES-1-i (MSB-first)
    typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] block_t;

    seq_state_t         state;
    block_t             tx_blk;
    block_t             rx_blk;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   next_idx;
    logic               timer_load;
    logic               timer_en;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;

    assign blk_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign blk_out   = rx_blk;
    assign next_idx  = idx + IDX_W'(1);

    // Arm the timeout as a byte is launched, re-arm with the gap once its reply lands
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TIMER_W'(TIMEOUT_CYCLES);
        timer_en    = (state == ST_WAIT) || (state == ST_GAP);
        if (state == ST_SEND) begin
            timer_load = 1'b1;
        end else if ((state == ST_WAIT) && m_done) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(GAP_CYCLES);
        end
    end

    spi_block_sequencer_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (timer_en),
        .expired    (timer_expired)
    );

    // Block sequencing FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tx_blk    <= '0;
            rx_blk    <= '0;
            idx       <= '0;
            m_data    <= '0;
            m_start   <= 1'b0;
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            m_start   <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        tx_blk  <= blk_in;
                        idx     <= '0;
                        error   <= 1'b0;
                        m_data  <= blk_in[BYTE_W*NUM_BYTES-1 -: BYTE_W];
                        m_start <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // m_done seen here belongs to no transfer of ours and is dropped
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rx_blk[LAST_IDX - idx] <= m_rdata;
                        state <= ST_GAP;
                    end else if (timer_expired) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // A lingering m_done is ignored here, so each byte captures once
                    if (timer_expired && !m_busy) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            idx     <= next_idx;
                            m_data  <= tx_blk[LAST_IDX - next_idx];
                            m_start <= 1'b1;
                            state   <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_block_sequencer.sv
// tb/tb_spi_block_sequencer.sv - randomized self-checking bench for spi_block_sequencer
module tb_spi_block_sequencer;

    localparam int NB  = 16;
    localparam int GAP = 2;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_in;
    logic [127:0] blk_out;
    logic         out_valid;
    logic         error;
    logic         busy;
    logic         m_start;
    logic [7:0]   m_data;
    logic         m_busy;
    logic         m_done;
    logic [7:0]   m_rdata;

    spi_block_sequencer #(
        .NUM_BYTES      (NB),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_in    (blk_in),
        .blk_out   (blk_out),
        .out_valid (out_valid),
        .error     (error),
        .busy      (busy),
        .m_start   (m_start),
        .m_data    (m_data),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rdata   (m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        logic [127:0] s;
        s = b >> (8 * (NB - 1 - i));
        return s[7:0];
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // slave configuration and bookkeeping
    int           cfg_t = 18;
    int           cfg_h = 1;
    int           cfg_e = 0;
    int           cfg_drop = -1;
    bit           cfg_ghost = 0;
    int           starts = 0;
    int           start_cyc = 0;
    int           start_total = 0;
    bit           resp = 0;
    logic [7:0]   sent = 8'h00;
    logic [127:0] cur_blk = '0;
    int           ov_total = 0;
    int           acc_cyc = 0;
    int           end_cyc = 0;
    bit           jitter = 0;

    // slave model: replies ~byte T cycles after m_start, busy until gap end plus extra
    initial begin
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset && m_start) begin
                if (starts > 0) check_eq("start_spacing", cyc - start_cyc, 1 + cfg_t + GAP + cfg_e);
                if (starts < NB) check_eq("m_data", m_data, byte_of(cur_blk, starts));
                start_cyc = cyc;
                sent      = m_data;
                resp      = (starts != cfg_drop);
                starts++;
                start_total++;
            end
            m_done  = (starts > 0) && resp && (cyc >= start_cyc + cfg_t) && (cyc < start_cyc + cfg_t + cfg_h);
            m_rdata = ~sent;
            if (m_start && cfg_ghost) begin
                m_done  = 1'b1;
                m_rdata = 8'h5A;
            end
            m_busy = (starts > 0) && (cyc >= start_cyc + 1) && (cyc <= start_cyc + cfg_t + GAP - 1 + cfg_e);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid) ov_total++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (jitter) blk_in = rand_blk();
        end
    end

    task automatic offer(input logic [127:0] blk, input bit hold);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        blk_valid = 1'b1;
        blk_in    = blk;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (blk_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("accept_timeout", 0, 1);
        acc_cyc = cyc;
        cur_blk = blk_in;
        starts  = 0;
        @(posedge clk);
        #1;
        if (!hold) begin
            blk_valid = 1'b0;
            blk_in    = rand_blk();
        end
    endtask

    task automatic wait_end(output int res);
        res = 2;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (out_valid) begin
                res = 0;
                end_cyc = cyc;
                break;
            end
            if (error) begin
                res = 1;
                end_cyc = cyc;
                break;
            end
        end
        if (res == 2) check_eq("end_timeout", 0, 1);
    endtask

    task automatic set_cfg(input int t, input int h, input int e, input bit ghost);
        cfg_t     = t;
        cfg_h     = h;
        cfg_e     = e;
        cfg_ghost = ghost;
        cfg_drop  = -1;
    endtask

    task automatic finish_block(input logic [127:0] blk, input int ov0);
        int res;
        wait_end(res);
        check_eq("end_kind", res, 0);
        check_eq("blk_out", blk_out, ~blk);
        check_eq("latency", end_cyc - acc_cyc, 1 + NB * (1 + cfg_t + GAP + cfg_e));
        check_eq("start_count", starts, NB);
        @(negedge clk);
        check_eq("ov_width", out_valid, 0);
        check_eq("ov_count", ov_total - ov0, 1);
        check_eq("ready_after", blk_ready, 1);
    endtask

    task automatic run_block(input logic [127:0] blk, input int t, input int h, input int e, input bit ghost);
        int ov0;
        set_cfg(t, h, e, ghost);
        ov0 = ov_total;
        offer(blk, 0);
        check_eq("err_cleared", error, 0);
        check_eq("busy_run", busy, 1);
        finish_block(blk, ov0);
    endtask

    initial begin
        logic [127:0] blk;
        logic [127:0] blk_a;
        logic [127:0] pre;
        int           res;
        int           ov0;
        int           st0;
        bit           ok;

        reset     = 1'b0;
        blk_valid = 1'b0;
        blk_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", blk_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ov", out_valid, 0);
        check_eq("rst_err", error, 0);
        check_eq("rst_mstart", m_start, 0);
        check_eq("rst_blkout", blk_out, 0);
        check_eq("rst_mdata", m_data, 0);

        // reference block, nominal slave
        blk = 128'h00112233445566778899AABBCCDDEEFF;
        run_block(blk, 18, 1, 0, 0);
        check_eq("ref_block", blk_out, 128'hFFEEDDCCBBAA99887766554433221100);

        // m_busy extended past the gap
        run_block(rand_blk(), 18, 1, 5, 0);
        // m_done held three cycles, then stray m_done alongside m_start
        run_block(rand_blk(), 18, 3, 0, 0);
        run_block(rand_blk(), 18, 2, 0, 1);

        // timeout on byte 4
        blk = rand_blk();
        set_cfg(18, 1, 0, 0);
        cfg_drop = 4;
        ov0 = ov_total;
        offer(blk, 0);
        wait_end(res);
        check_eq("tmo_kind", res, 1);
        check_eq("tmo_cycles", end_cyc - start_cyc, TMO + 1);
        check_eq("tmo_starts", starts, 5);
        check_eq("tmo_ready", blk_ready, 1);
        check_eq("tmo_busy", busy, 0);
        pre = ~blk;
        check_eq("tmo_partial", blk_out[127:96], pre[127:96]);
        repeat (3) @(negedge clk);
        check_eq("tmo_sticky", error, 1);
        check_eq("tmo_no_ov", ov_total - ov0, 0);
        run_block(rand_blk(), 18, 1, 0, 0);

        // reset while waiting on byte 7
        set_cfg(18, 1, 0, 0);
        ov0 = ov_total;
        offer(rand_blk(), 0);
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (starts >= 8) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_eq("byte7_timeout", 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        starts = 0;
        #1;
        check_eq("mid_rst_ready", blk_ready, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_mstart", m_start, 0);
        check_eq("mid_rst_ov", out_valid, 0);
        check_eq("mid_rst_err", error, 0);
        check_eq("mid_rst_blkout", blk_out, 0);
        check_eq("mid_rst_mdata", m_data, 0);
        st0 = start_total;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_rst_starts", start_total - st0, 0);
        check_eq("post_rst_ov", ov_total - ov0, 0);

        // randomized traffic
        for (int k = 0; k < 5; k++) begin
            run_block(rand_blk(), int'($urandom_range(20, 2)), int'($urandom_range(3, 1)),
                      int'($urandom_range(5, 0)), bit'($urandom_range(1, 0)));
        end

        // blk_valid held with wandering blk_in across two blocks
        set_cfg(int'($urandom_range(12, 3)), 1, 0, 0);
        ov0 = ov_total;
        offer(rand_blk(), 1);
        blk_a = cur_blk;
        jitter = 1;
        wait_end(res);
        check_eq("hold_kind", res, 0);
        check_eq("hold_blk_a", blk_out, ~blk_a);
        @(negedge clk);
        check_eq("hold_reaccept", blk_ready, 1);
        acc_cyc = cyc;
        check_eq("hold_acc_gap", acc_cyc - end_cyc, 1);
        cur_blk = blk_in;
        starts  = 0;
        blk = blk_in;
        @(posedge clk);
        #1;
        jitter    = 0;
        blk_valid = 1'b0;
        finish_block(blk, ov0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
